// File: rtl/register_writeback_pkg.sv
// Shared constants, result-entry type and load formatting for the writeback slice.
package register_writeback_pkg;

  localparam int XLEN           = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int NUM_REGS       = 1 << REG_ADDR_WIDTH;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_funct3_e;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [XLEN-1:0]           value;
  } wb_entry_t;

  // Extracts the addressed byte/half from an aligned word and extends it.
  function automatic logic [XLEN-1:0] formatLoad(
    input logic [2:0]      funct3,
    input logic [1:0]      offset,
    input logic [XLEN-1:0] data
  );
    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    byteSel = data[{offset, 3'b000} +: 8];
    halfSel = offset[1] ? data[31:16] : data[15:0];
    case (funct3)
      F3_LB:   formatLoad = {{(XLEN-8){byteSel[7]}}, byteSel};
      F3_LH:   formatLoad = {{(XLEN-16){halfSel[15]}}, halfSel};
      F3_LW:   formatLoad = data;
      F3_LBU:  formatLoad = {{(XLEN-8){1'b0}}, byteSel};
      F3_LHU:  formatLoad = {{(XLEN-16){1'b0}}, halfSel};
      default: formatLoad = '0;
    endcase
  endfunction

endpackage

// File: rtl/register_writeback_fifo.sv
// Result buffer taking up to two entries and releasing one per cycle; when empty,
// the first incoming entry is forwarded straight to the dequeue port.
module writeback_fifo
  import register_writeback_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enqAValid_i,
  input  wb_entry_t                enqAData_i,
  input  logic                     enqBValid_i,
  input  wb_entry_t                enqBData_i,
  output logic                     deqValid_o,
  output wb_entry_t                deqData_o,
  output logic [$clog2(DEPTH):0]   free_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_entry_t     mem_q [DEPTH];
  logic [AW-1:0] rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d, wrPtrNext;
  logic [CW-1:0] count_q, count_d, free_q, free_d;
  logic          empty, firstValid, secondValid, storeA, storeB;
  wb_entry_t     firstData, secondData, dataA;

  always_comb begin
    empty       = (count_q == '0);
    firstValid  = enqAValid_i | enqBValid_i;
    firstData   = enqAValid_i ? enqAData_i : enqBData_i;
    secondValid = enqAValid_i & enqBValid_i;
    secondData  = enqBData_i;
    deqValid_o  = !empty || firstValid;
    deqData_o   = empty ? firstData : mem_q[rdPtr_q];
    // An empty buffer hands its first entry out directly, so only the second is stored.
    storeA      = empty ? secondValid : firstValid;
    dataA       = empty ? secondData : firstData;
    storeB      = !empty && secondValid;
    wrPtrNext   = wrPtr_q + AW'(1);
    rdPtr_d     = rdPtr_q + AW'(!empty);
    wrPtr_d     = wrPtr_q + AW'(storeA) + AW'(storeB);
    count_d     = count_q + CW'(storeA) + CW'(storeB) - CW'(!empty);
    free_d      = CW'(DEPTH) - count_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
      free_q  <= CW'(DEPTH);
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
      free_q  <= free_d;
    end
  end

  always_ff @(posedge clock) begin
    if (storeA) mem_q[wrPtr_q] <= dataA;
    if (storeB) mem_q[wrPtrNext] <= secondData;
  end

  assign free_o = free_q;

endmodule

// File: rtl/register_writeback.sv
// Writeback stage: formats load results, buffers ALU/load results, drives one
// register-file write per cycle and tracks pending writes per register.
module register_writeback
  import register_writeback_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PEND_WIDTH = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
  input  logic [XLEN-1:0]           alu_value,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [REG_ADDR_WIDTH-1:0] load_rd,
  input  logic [XLEN-1:0]           load_data,
  input  logic [2:0]                load_funct3,
  input  logic [1:0]                load_offset,
  input  logic                      issue_valid,
  output logic                      issue_ready,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
  input  logic [REG_ADDR_WIDTH-1:0] rs1,
  input  logic [REG_ADDR_WIDTH-1:0] rs2,
  output logic                      rs1_busy,
  output logic                      rs2_busy,
  output logic                      register_file_write_enable,
  output logic [REG_ADDR_WIDTH-1:0] rd,
  output logic [XLEN-1:0]           rd_value
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [CW-1:0]             free;
  logic                      loadFire, aluFire, issueFire;
  logic                      enqAValid, enqBValid, deqValid;
  wb_entry_t                 enqAData, enqBData, deqData;
  logic [PEND_WIDTH-1:0]     pendCount_q [NUM_REGS];
  logic [PEND_WIDTH-1:0]     pendCount_d [NUM_REGS];
  logic                      writeEnable_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic [XLEN-1:0]           rdValue_q;

  // The load takes the first slot, so the ALU needs a second free entry alongside it.
  always_comb begin
    load_ready = (free >= CW'(1));
    alu_ready  = load_valid ? (free >= CW'(2)) : (free >= CW'(1));
    loadFire   = load_valid && load_ready;
    aluFire    = alu_valid && alu_ready;
    enqAValid  = loadFire && (load_rd != '0);
    enqAData   = '{rd: load_rd, value: formatLoad(load_funct3, load_offset, load_data)};
    enqBValid  = aluFire && (alu_rd != '0);
    enqBData   = '{rd: alu_rd, value: alu_value};
  end

  writeback_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .enqAValid_i(enqAValid),
    .enqAData_i (enqAData),
    .enqBValid_i(enqBValid),
    .enqBData_i (enqBData),
    .deqValid_o (deqValid),
    .deqData_o  (deqData),
    .free_o     (free)
  );

  always_comb begin
    issue_ready = (issue_rd == '0) || (pendCount_q[issue_rd] != '1);
    issueFire   = issue_valid && issue_ready && (issue_rd != '0);
    rs1_busy    = (rs1 != '0) && (pendCount_q[rs1] != '0);
    rs2_busy    = (rs2 != '0) && (pendCount_q[rs2] != '0);
  end

  // An issue and a retire of the same register cancel; a retire never wraps below zero.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      pendCount_d[r] = pendCount_q[r];
      if (r != 0) begin
        if (issueFire && (issue_rd == REG_ADDR_WIDTH'(r)) &&
            !(deqValid && (deqData.rd == REG_ADDR_WIDTH'(r)))) begin
          pendCount_d[r] = pendCount_q[r] + PEND_WIDTH'(1);
        end else if (deqValid && (deqData.rd == REG_ADDR_WIDTH'(r)) &&
                     !(issueFire && (issue_rd == REG_ADDR_WIDTH'(r))) &&
                     (pendCount_q[r] != '0)) begin
          pendCount_d[r] = pendCount_q[r] - PEND_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) pendCount_q[r] <= '0;
      writeEnable_q <= 1'b0;
      rd_q          <= '0;
      rdValue_q     <= '0;
    end else begin
      pendCount_q   <= pendCount_d;
      writeEnable_q <= deqValid;
      if (deqValid) begin
        rd_q      <= deqData.rd;
        rdValue_q <= deqData.value;
      end
    end
  end

  assign register_file_write_enable = writeEnable_q;
  assign rd                         = rd_q;
  assign rd_value                   = rdValue_q;

  // A retiring result must have been announced through issue beforehand.
  assert property (@(posedge clock) disable iff (reset)
    (deqValid && (deqData.rd != '0)) |-> (pendCount_q[deqData.rd] != '0));

endmodule
